// File: rtl/r88_pkg.sv
`default_nettype none
// ============================================================================
// Module   : r88_pkg
// Purpose  : Shared constants and helpers for the R88 interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package r88_pkg;

    localparam logic [1:0]  c_offPend       = 2'd0;
    localparam logic [1:0]  c_offMask       = 2'd1;
    localparam logic [1:0]  c_offVector     = 2'd2;
    localparam logic [1:0]  c_offNmiAck     = 2'd3;

    localparam logic [7:0]  c_vecNone       = 8'h80;

    localparam logic [15:0] c_defBaseAddr   = 16'hFFF0;
    localparam int          c_defRstStretch = 16;

    // Index of the lowest set bit; callers qualify the result with |v.
    function automatic logic [2:0] lowestSet(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/r88_sync.sv
`default_nettype none
// ============================================================================
// Module   : r88_sync
// Purpose  : Two-stage flop synchronizer with asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module r88_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/r88_intctl.sv
`default_nettype none
// ============================================================================
// Module   : r88_intctl
// Purpose  : 8-source edge-latched interrupt controller with NMI, a 4-byte
//            bus register window and a stretched core reset request.
// Revision : 1.0 - initial release
// ============================================================================
module r88_intctl
    import r88_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = c_defBaseAddr,
    parameter int          RST_STRETCH = c_defRstStretch
) (
    input  logic        sysClock,
    input  logic        resetReq,
    input  logic [7:0]  irqSrc,
    input  logic        nmiSrc,
    input  logic [15:0] extA,
    inout  wire  [7:0]  extD,
    input  logic        readMem,
    input  logic        writeMem,
    output logic        irq,
    output logic        nmiReq,
    output logic        coreResetReq
);

    localparam int c_cntW = (RST_STRETCH < 2) ? 1 : $clog2(RST_STRETCH + 1);

    logic              w_relSync;
    logic [c_cntW-1:0] r_stretch;
    logic [8:0]        w_srcSync;
    logic [8:0]        r_srcPrev;
    logic [8:0]        w_rise;
    logic [7:0]        r_pend;
    logic [7:0]        r_mask;
    logic              r_nmiPend;
    logic              r_readPrev;
    logic [16:0]       w_addrOff;
    logic [1:0]        w_offset;
    logic              w_hit;
    logic              w_active;
    logic              w_rdSel;
    logic              w_wrSel;
    logic              w_rdStrobe;
    logic [7:0]        w_pendMasked;
    logic              w_anyMasked;
    logic [2:0]        w_vecIdx;
    logic [7:0]        w_rdData;
    logic [7:0]        w_pendClr;
    logic              w_nmiClr;

    r88_sync #(.WIDTH(1)) u_rstSync (
        .clk   (sysClock),
        .rst_n (resetReq),
        .i_d   (1'b1),
        .o_q   (w_relSync)
    );

    r88_sync #(.WIDTH(9)) u_srcSync (
        .clk   (sysClock),
        .rst_n (resetReq),
        .i_d   ({nmiSrc, irqSrc}),
        .o_q   (w_srcSync)
    );

    // Countdown starts only once the synchronized release arrives.
    always_ff @(posedge sysClock or negedge resetReq) begin
        if (!resetReq) begin
            r_stretch <= c_cntW'(RST_STRETCH);
        end else if (w_relSync && (r_stretch != '0)) begin
            r_stretch <= r_stretch - 1'b1;
        end
    end

    assign coreResetReq = !w_relSync || (r_stretch != '0);
    assign w_active     = !coreResetReq;

    // 17-bit difference: addresses below the base wrap far above 3.
    assign w_addrOff = {1'b0, extA} - {1'b0, BASE_ADDR};
    assign w_hit     = (w_addrOff < 17'd4);
    assign w_offset  = w_addrOff[1:0];

    assign w_rdSel    = readMem && !writeMem && w_hit && w_active;
    assign w_wrSel    = writeMem && !readMem && w_hit && w_active;
    assign w_rdStrobe = w_rdSel && !r_readPrev;

    assign w_rise       = w_active ? (w_srcSync & ~r_srcPrev) : 9'd0;
    assign w_pendMasked = r_pend & r_mask;
    assign w_anyMasked  = |w_pendMasked;
    assign w_vecIdx     = lowestSet(w_pendMasked);

    always_comb begin
        w_rdData  = 8'h00;
        w_pendClr = 8'h00;
        w_nmiClr  = 1'b0;
        case (w_offset)
            c_offPend:   w_rdData = r_pend;
            c_offMask:   w_rdData = r_mask;
            c_offVector: w_rdData = w_anyMasked ? {5'b0, w_vecIdx} : c_vecNone;
            default:     w_rdData = {7'b0, r_nmiPend};
        endcase
        if (w_rdStrobe && (w_offset == c_offVector) && w_anyMasked) begin
            w_pendClr = 8'b1 << w_vecIdx;
        end
        if (w_rdStrobe && (w_offset == c_offNmiAck)) begin
            w_nmiClr = 1'b1;
        end
        if (w_wrSel && (w_offset == c_offPend)) begin
            w_pendClr = extD;
        end
    end

    // A fresh edge is OR-ed in after the clear so it survives a same-cycle clear.
    always_ff @(posedge sysClock or negedge resetReq) begin
        if (!resetReq) begin
            r_srcPrev  <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_nmiPend  <= 1'b0;
            r_readPrev <= 1'b0;
        end else begin
            r_srcPrev  <= w_srcSync;
            r_readPrev <= readMem;
            r_pend     <= (r_pend & ~w_pendClr) | w_rise[7:0];
            r_nmiPend  <= (r_nmiPend & ~w_nmiClr) | w_rise[8];
            if (w_wrSel && (w_offset == c_offMask)) begin
                r_mask <= extD;
            end
        end
    end

    assign irq    = w_anyMasked;
    assign nmiReq = r_nmiPend;
    assign extD   = w_rdSel ? w_rdData : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_r88_intctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_r88_intctl
// Purpose  : Self-checking bench for r88_intctl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_r88_intctl;

    localparam logic [15:0] c_base = 16'hFFF0;

    logic       sysClock;
    logic       resetReq;
    logic [7:0] irqSrc;
    logic       nmiSrc;
    logic [15:0] extA;
    tri1  [7:0] extD;
    logic       readMem;
    logic       writeMem;
    logic       irq;
    logic       nmiReq;
    logic       coreResetReq;

    logic       tbDrv;
    logic [7:0] tbData;
    assign extD = tbDrv ? tbData : 8'hzz;

    int errors = 0;
    int checks = 0;

    // Reference model state, updated from the register rules directly.
    logic [7:0] mPend;
    logic [7:0] mMask;

    r88_intctl #(.BASE_ADDR(c_base), .RST_STRETCH(16)) dut (
        .sysClock     (sysClock),
        .resetReq     (resetReq),
        .irqSrc       (irqSrc),
        .nmiSrc       (nmiSrc),
        .extA         (extA),
        .extD         (extD),
        .readMem      (readMem),
        .writeMem     (writeMem),
        .irq          (irq),
        .nmiReq       (nmiReq),
        .coreResetReq (coreResetReq)
    );

    initial sysClock = 1'b0;
    always #5 sysClock = ~sysClock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sysClock);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] off, input logic [7:0] data);
        extA     = c_base + 16'(off);
        tbData   = data;
        tbDrv    = 1'b1;
        writeMem = 1'b1;
        tick();
        writeMem = 1'b0;
        tbDrv    = 1'b0;
        extA     = 16'h0000;
    endtask

    task automatic busRead(input logic [15:0] addr, input int hold, output logic [7:0] data);
        extA    = addr;
        readMem = 1'b1;
        @(negedge sysClock);
        data = extD;
        repeat (hold) tick();
        readMem = 1'b0;
        extA    = 16'h0000;
        tick();
    endtask

    task automatic pulseIrq(input logic [7:0] bits);
        irqSrc = bits;
        repeat (4) tick();
        irqSrc = 8'h00;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        repeat (3) tick();
        checks++;
        if (coreResetReq !== 1'b1 || irq !== 1'b0 || nmiReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got core=%b irq=%b nmi=%b expected 1 0 0", coreResetReq, irq, nmiReq);
        end
        busRead(c_base, 1, d);
        checks++;
        if (d !== 8'hFF) begin
            errors++;
            $display("FAIL reset_no_drive: got %h expected ff (undriven)", d);
        end
        resetReq = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge sysClock);
            @(negedge sysClock);
            checks++;
            if (coreResetReq !== (k < 18) || irq !== 1'b0 || nmiReq !== 1'b0) begin
                errors++;
                $display("FAIL stretch_cycle%0d: got core=%b irq=%b nmi=%b expected %b 0 0",
                         k, coreResetReq, irq, nmiReq, (k < 18));
            end
        end
        tick();
    endtask

    task automatic test_vector();
        logic [7:0] d;
        busWrite(2'd1, 8'h0C);
        irqSrc = 8'h08;
        for (int k = 1; k <= 3; k++) begin
            @(posedge sysClock);
            @(negedge sysClock);
            if (k >= 2) begin
                checks++;
                if (irq !== (k == 3)) begin
                    errors++;
                    $display("FAIL irq_latency_edge%0d: got %b expected %b", k, irq, (k == 3));
                end
            end
        end
        tick();
        irqSrc = 8'h00;
        repeat (3) tick();
        pulseIrq(8'h04);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL vec_irq_high: got %b expected 1", irq);
        end
        busRead(c_base + 16'd2, 1, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL vec_read1: got %h expected 02", d); end
        busRead(c_base + 16'd2, 1, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL vec_read2: got %h expected 03", d); end
        busRead(c_base + 16'd2, 1, d);
        checks++;
        if (d !== 8'h80 || irq !== 1'b0) begin
            errors++;
            $display("FAIL vec_read3: got %h irq=%b expected 80 irq=0", d, irq);
        end
    endtask

    task automatic test_masked();
        logic [7:0] d;
        busWrite(2'd1, 8'h00);
        pulseIrq(8'h20);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b expected 0", irq); end
        busRead(c_base, 1, d);
        checks++;
        if (d !== 8'h20) begin errors++; $display("FAIL masked_pend: got %h expected 20", d); end
        busWrite(2'd0, 8'h20);
        busRead(c_base, 1, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL w1c_pend: got %h expected 00", d); end
    endtask

    task automatic test_nmi();
        logic [7:0] d;
        nmiSrc = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge sysClock);
            @(negedge sysClock);
            if (k >= 2) begin
                checks++;
                if (nmiReq !== (k == 3)) begin
                    errors++;
                    $display("FAIL nmi_latency_edge%0d: got %b expected %b", k, nmiReq, (k == 3));
                end
            end
        end
        tick();
        nmiSrc = 1'b0;
        repeat (3) tick();
        busRead(c_base + 16'd3, 4, d);
        checks++;
        if (d !== 8'h01 || nmiReq !== 1'b0) begin
            errors++;
            $display("FAIL nmiack_read1: got %h nmi=%b expected 01 nmi=0", d, nmiReq);
        end
        busRead(c_base + 16'd3, 1, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL nmiack_read2: got %h expected 00", d); end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        logic [7:0] v;
        busWrite(2'd1, 8'h01);
        pulseIrq(8'h01);
        irqSrc = 8'h01;
        tick();
        tick();
        extA    = c_base + 16'd2;
        readMem = 1'b1;
        @(negedge sysClock);
        v = extD;
        tick();
        readMem = 1'b0;
        extA    = 16'h0000;
        tick();
        irqSrc = 8'h00;
        repeat (3) tick();
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL collide_vec: got %h expected 00", v); end
        busRead(c_base, 1, d);
        checks++;
        if (d !== 8'h01 || irq !== 1'b1) begin
            errors++;
            $display("FAIL collide_pend: got %h irq=%b expected 01 irq=1", d, irq);
        end
        busRead(c_base + 16'd2, 1, d);
        busRead(c_base, 1, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL collide_clear: got %h expected 00", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        busWrite(2'd1, 8'hFF);
        pulseIrq(8'h06);
        busRead(c_base + 16'd2, 3, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL held_vec: got %h expected 01", d); end
        busRead(c_base, 1, d);
        checks++;
        if (d !== 8'h04) begin errors++; $display("FAIL held_single_clear: got %h expected 04", d); end
        busWrite(2'd0, 8'hFF);
        busWrite(2'd1, 8'h5A);
        extA     = c_base + 16'd1;
        readMem  = 1'b1;
        writeMem = 1'b1;
        @(negedge sysClock);
        d = extD;
        tick();
        readMem  = 1'b0;
        writeMem = 1'b0;
        extA     = 16'h0000;
        tick();
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL both_strobe_drive: got %h expected ff", d); end
        busRead(c_base + 16'd1, 1, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL both_strobe_mask: got %h expected 5a", d); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] bits;
        logic [7:0] exp;
        int         op;
        busWrite(2'd0, 8'hFF);
        mPend = 8'h00;
        for (int it = 0; it < 24; it++) begin
            mMask = 8'($urandom);
            busWrite(2'd1, mMask);
            bits = 8'($urandom) & 8'($urandom);
            pulseIrq(bits);
            mPend = mPend | bits;
            checks++;
            if (irq !== ((mPend & mMask) != 8'h00)) begin
                errors++;
                $display("FAIL rand_irq_it%0d: got %b expected %b", it, irq, ((mPend & mMask) != 8'h00));
            end
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                busRead(c_base, 1, d);
                checks++;
                if (d !== mPend) begin errors++; $display("FAIL rand_pend_it%0d: got %h expected %h", it, d, mPend); end
            end else if (op == 1) begin
                exp = 8'h80;
                for (int i = 7; i >= 0; i--) if (mPend[i] && mMask[i]) exp = 8'(i);
                busRead(c_base + 16'd2, 1, d);
                checks++;
                if (d !== exp) begin errors++; $display("FAIL rand_vec_it%0d: got %h expected %h", it, d, exp); end
                if (exp != 8'h80) mPend[exp[2:0]] = 1'b0;
            end else begin
                bits = 8'($urandom);
                busWrite(2'd0, bits);
                mPend = mPend & ~bits;
            end
        end
        busRead(c_base, 1, d);
        checks++;
        if (d !== mPend) begin errors++; $display("FAIL rand_final_pend: got %h expected %h", d, mPend); end
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        busWrite(2'd1, 8'hFF);
        irqSrc = 8'hFF;
        nmiSrc = 1'b1;
        repeat (4) tick();
        irqSrc = 8'h00;
        nmiSrc = 1'b0;
        repeat (3) tick();
        busRead(c_base, 1, d);
        checks++;
        if (d !== 8'hFF || irq !== 1'b1 || nmiReq !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got pend=%h irq=%b nmi=%b expected ff 1 1", d, irq, nmiReq);
        end
        @(negedge sysClock);
        #2;
        resetReq = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || nmiReq !== 1'b0 || coreResetReq !== 1'b1 || dut.r_pend !== 8'h00) begin
            errors++;
            $display("FAIL async_clear: got irq=%b nmi=%b core=%b pend=%h expected 0 0 1 00",
                     irq, nmiReq, coreResetReq, dut.r_pend);
        end
        extA    = 16'hFFEF;
        readMem = 1'b1;
        #1;
        checks++;
        if (extD !== 8'hFF) begin errors++; $display("FAIL below_base_in_reset: got %h expected ff", extD); end
        readMem = 1'b0;
        extA    = 16'h0000;
        tick();
        resetReq = 1'b1;
        repeat (17) tick();
        checks++;
        if (coreResetReq !== 1'b1) begin errors++; $display("FAIL restretch17: got %b expected 1", coreResetReq); end
        tick();
        checks++;
        if (coreResetReq !== 1'b0) begin errors++; $display("FAIL restretch18: got %b expected 0", coreResetReq); end
        busRead(c_base, 1, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL post_reset_pend: got %h expected 00", d); end
        busRead(16'hFFEF, 1, d);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL below_base: got %h expected ff", d); end
    endtask

    initial begin
        resetReq = 1'b0;
        irqSrc   = 8'h00;
        nmiSrc   = 1'b0;
        extA     = 16'h0000;
        readMem  = 1'b0;
        writeMem = 1'b0;
        tbDrv    = 1'b0;
        tbData   = 8'h00;
        mPend    = 8'h00;
        mMask    = 8'h00;
        #1;
        test_reset();
        test_vector();
        test_masked();
        test_nmi();
        test_collision();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/r88_intctl.md
R88_INTCTL -- requirements
Module: r88_intctl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFFF0, meaning the base of the 4-byte register window (offsets 0-3).
REQ-002 SHALL have parameter RST_STRETCH, default 16, meaning the number of cycles coreResetReq is held after resetReq releases.
REQ-003 SHALL have port sysClock, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port resetReq, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port irqSrc, input, 8 bits: asynchronous interrupt sources; bit 0 has the highest priority.
REQ-006 SHALL have port nmiSrc, input, 1 bit: asynchronous NMI source, rising-edge triggered.
REQ-007 SHALL have port extA, input, 16 bits: the core address bus.
REQ-008 SHALL have port extD, inout, 8 bits: the core data bus.
REQ-009 SHALL have port readMem, input, 1 bit: the core read strobe.
REQ-010 SHALL have port writeMem, input, 1 bit: the core write strobe.
REQ-011 SHALL have port irq, output, 1 bit: maskable interrupt request to the core.
REQ-012 SHALL have port nmiReq, output, 1 bit: NMI request to the core.
REQ-013 SHALL have port coreResetReq, output, 1 bit: active-high reset request to the core.

Function
REQ-014 SHALL pass irqSrc and nmiSrc through 2-flop synchronizers and then detect rising edges using a registered copy.
REQ-015 SHALL set PEND[i] on a detected rising edge of irqSrc[i]; irq rises on the 3rd sysClock edge after irqSrc[i] rises.
REQ-016 SHALL drive irq = |(PEND & MASK), combinationally from registers.
REQ-017 SHALL set nmiPend on a detected nmiSrc edge; nmiReq = nmiPend, held until acknowledged; MASK has no effect on it.
REQ-018 SHALL define hit = extA in [BASE_ADDR, BASE_ADDR+3].
REQ-019 SHALL decode offset 0 as PEND: read returns PEND; write clears the bits written as 1 (write-1-to-clear).
REQ-020 SHALL decode offset 1 as MASK: read/write.
REQ-021 SHALL decode offset 2 as VECTOR: read returns {5'b0, idx}, where idx is the lowest set bit of PEND&MASK, or 8'h80 if none; the read clears PEND[idx].
REQ-022 SHALL decode offset 3 as NMIACK: read returns {7'b0, nmiPend}; the read clears nmiPend.
REQ-023 SHALL drive extD combinationally while readMem && hit, and hold extD at high-Z otherwise.
REQ-024 SHALL capture writes on the sysClock edge where writeMem && hit.
REQ-025 SHALL apply read side effects exactly once per strobe, on the first cycle of readMem assertion (detected against registered readMem).
REQ-026 SHALL let a new edge win when it is set in the same cycle as a clear of the same bit: the bit stays 1.
REQ-027 SHALL ignore an access with readMem and writeMem both high: no drive, no side effects.
REQ-028 SHALL latch edges into PEND regardless of MASK, so masked sources remain visible in PEND.

Reset
REQ-029 SHALL, while resetReq is low, reset PEND, MASK, nmiPend, the synchronizers and the edge registers to 0, and reset irq and nmiReq to 0.
REQ-030 SHALL hold coreResetReq = 1 while resetReq is low, and for exactly RST_STRETCH cycles after resetReq synchronously deasserts (2-flop release), then drive it to 0.
REQ-031 SHALL ignore bus accesses and source edges while coreResetReq = 1; PEND stays 0.
REQ-032 SHALL, on resetReq asserted mid-operation, clear all state immediately (asynchronously) and restart the stretch counter.

Structure
REQ-033 SHALL place register offset constants, the VECTOR "none" value 8'h80, and the default BASE_ADDR and RST_STRETCH in shared package r88_pkg.
REQ-034 SHALL implement the synchronizer as sub-module r88_sync (parameterised width, 2 stages, async active-low reset), instantiated once for {nmiSrc, irqSrc} and once for reset release.

Verification
REQ-035 SHALL cover: release resetReq -> coreResetReq = 1 for 2+16 cycles, then 0; all outputs 0 throughout.
REQ-036 SHALL cover: write MASK=8'h0C, then pulse irqSrc[3] then irqSrc[2] -> irq=1; read VECTOR -> 8'h02; read again -> 8'h03; read again -> 8'h80, irq=0.
REQ-037 SHALL cover: MASK=8'h00, pulse irqSrc[5] -> irq stays 0, PEND reads 8'h20; write PEND=8'h20 -> PEND reads 8'h00.
REQ-038 SHALL cover: nmiSrc rising edge -> nmiReq=1 after 3 cycles; read NMIACK held 4 cycles -> returns 8'h01, single clear; next read returns 8'h00.
REQ-039 SHALL cover: irqSrc[0] edge landing in the same cycle as the VECTOR read that clears bit 0 -> PEND[0] remains 1, irq stays 1.
REQ-040 SHALL cover: resetReq low mid-pending (PEND=8'hFF, nmiPend=1) -> irq, nmiReq and PEND reach 0 without a clock edge; access to extA=16'hFFEF -> extD stays high-Z.
